// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and long-latency scoreboard feeding the single
// register-file write port.
//   clk, reset (async, active-low)
//   pipe_valid/pipe_addr/pipe_data : in-order pipeline result (highest priority)
//   pipe_hold                      : asks the pipeline for a writeback bubble
//   lu_valid/lu_ready/lu_addr/lu_data : long-latency result into the FIFO
//   issue_lu_valid/issue_lu_addr   : marks a destination as pending
//   rs1_addr/rs2_addr/rd_addr      : issue-stage indices checked against pending
//   stall, pending                 : hazard stall and scoreboard bitmap
//   we/wb_addr/wb_data             : registered register-file write port
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  output logic        pipe_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic        issue_lu_valid,
  input  logic [4:0]  issue_lu_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic [31:0] pending,
  output logic        we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_hold;
  logic [31:0]   r_pending;
  logic          r_we;
  logic [4:0]    r_wb_addr;
  logic [31:0]   r_wb_data;
  logic          r_from_lu;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_sel_addr;
  logic [31:0]   w_sel_data;
  logic          w_sel_valid;
  logic [SW-1:0] w_starve_next;
  logic [31:0]   w_pend_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_push  = lu_valid & ~w_full;
  // The pipeline always wins; the FIFO head drains only in pipeline bubbles.
  assign w_pop   = ~pipe_valid & ~w_empty;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = pipe_addr;
    w_sel_data  = pipe_data;
    if (pipe_valid) begin
      w_sel_valid = 1'b1;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = r_fifo_addr[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
    end
  end

  // Counter saturates at the limit; it only matters up to the hold threshold.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty) begin
      w_starve_next = '0;
    end else if (pipe_valid && (r_starve != SW'(STARVE_LIMIT))) begin
      w_starve_next = r_starve + SW'(1);
    end
  end

  // Clear uses the write currently on the port (it commits at this edge);
  // a same-edge re-issue of that register must keep it pending.
  always_comb begin
    w_pend_next = r_pending;
    if (r_we && r_from_lu) begin
      w_pend_next[r_wb_addr] = 1'b0;
    end
    if (issue_lu_valid && (issue_lu_addr != 5'd0)) begin
      w_pend_next[issue_lu_addr] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= lu_addr;
      r_fifo_data[r_wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_hold    <= 1'b0;
      r_pending <= '0;
      r_we      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_from_lu <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_next;
      if (w_pop) begin
        r_hold <= 1'b0;
      end else if (w_starve_next == SW'(STARVE_LIMIT)) begin
        r_hold <= 1'b1;
      end
      r_pending <= w_pend_next;
      r_we      <= w_sel_valid & (w_sel_addr != 5'd0);
      r_wb_addr <= w_sel_addr;
      r_wb_data <= w_sel_data;
      r_from_lu <= w_pop;
    end
  end

  assign lu_ready  = ~w_full;
  assign pipe_hold = r_hold;
  assign pending   = r_pending;
  assign we        = r_we;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign stall     = r_pending[rs1_addr] | r_pending[rs2_addr] | r_pending[rd_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: a queue-level reference model predicts every
// register-file write; a negedge monitor pops and compares them, along with
// lu_ready, pipe_hold, pending and stall.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_hold;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        issue_lu_valid = 1'b0;
  logic [4:0]  issue_lu_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        stall;
  logic [31:0] pending;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad = 0;
  bit in_reset = 1'b1;

  // Reference model state
  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [31:0] mpend = '0;
  int          mstarve = 0;
  bit          mhold = 1'b0;
  int          last_lu_addr = 0;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_hold(pipe_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .issue_lu_valid(issue_lu_valid), .issue_lu_addr(issue_lu_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .stall(stall), .pending(pending),
    .we(we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model using the inputs that edge saw.
  task automatic model_edge(output bit accepted);
    bit   was_empty;
    bit   popped;
    int   sel_lu;
    ent_t e;
    was_empty = (mq.size() == 0);
    accepted  = lu_valid && (mq.size() < DEPTH);
    popped    = 1'b0;
    sel_lu    = 0;
    if (pipe_valid) begin
      e.a = pipe_addr;
      e.d = pipe_data;
      if (e.a != 0) exp_q.push_back(e);
    end else if (!was_empty) begin
      e = mq.pop_front();
      popped = 1'b1;
      sel_lu = int'(e.a);
      if (e.a != 0) exp_q.push_back(e);
    end
    if (last_lu_addr != 0) mpend[last_lu_addr] = 1'b0;
    if (issue_lu_valid && issue_lu_addr != 0) mpend[issue_lu_addr] = 1'b1;
    last_lu_addr = sel_lu;
    if (popped || was_empty) mstarve = 0;
    else if (pipe_valid && mstarve < LIMIT) mstarve++;
    if (popped) mhold = 1'b0;
    else if (mstarve >= LIMIT) mhold = 1'b1;
    if (accepted) begin
      e.a = lu_addr;
      e.d = lu_data;
      mq.push_back(e);
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic drive(input int pv, input bit obey, input int lu, input int iss);
    pipe_valid = ($urandom_range(0, 99) < pv) && !(obey && mhold);
    pipe_addr  = rnd_addr();
    pipe_data  = $urandom;
    if (!lu_valid) begin
      // A refused offer is held unchanged until accepted.
      lu_valid = ($urandom_range(0, 99) < lu);
      lu_addr  = rnd_addr();
      lu_data  = $urandom;
    end
    issue_lu_valid = ($urandom_range(0, 99) < iss);
    issue_lu_addr  = rnd_addr();
    rs1_addr = rnd_addr();
    rs2_addr = rnd_addr();
    rd_addr  = rnd_addr();
  endtask

  task automatic step(input int pv, input bit obey, input int lu, input int iss);
    bit acc;
    @(posedge clk);
    #1;
    model_edge(acc);
    if (acc) lu_valid = 1'b0;
    drive(pv, obey, lu, iss);
  endtask

  task automatic zero_inputs();
    pipe_valid = 1'b0; lu_valid = 1'b0; issue_lu_valid = 1'b0;
    pipe_addr = '0; pipe_data = '0; lu_addr = '0; lu_data = '0;
    issue_lu_addr = '0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},       64'(we),        64'(0));
    chk({tag, "_pending"},  64'(pending),   64'(0));
    chk({tag, "_lu_ready"}, 64'(lu_ready),  64'(1));
    chk({tag, "_pipe_hold"},64'(pipe_hold), 64'(0));
    chk({tag, "_stall"},    64'(stall),     64'(0));
  endtask

  // Monitor: every DUT write must match the oldest predicted write.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got addr %0d data %h expected no write at %0t",
                   wb_addr, wb_data, $time);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wb_write", {27'd0, wb_addr, wb_data}, {27'd0, e.a, e.d});
        end
      end
      chk("lu_ready",  64'(lu_ready),  64'(mq.size() < DEPTH));
      chk("pipe_hold", 64'(pipe_hold), 64'(mhold));
      chk("pending",   64'(pending),   64'(mpend));
      chk("stall",     64'(stall),
          64'(mpend[rs1_addr] | mpend[rs2_addr] | mpend[rd_addr]));
    end
  end

  initial begin
    int full_seen;
    zero_inputs();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    #1;
    reset = 1'b1;
    in_reset = 1'b0;

    // Mixed traffic
    repeat (400) step(50, 1'b1, 40, 30);
    // Heavy pipeline that honours pipe_hold: exercises starvation relief
    repeat (300) step(95, 1'b1, 30, 30);
    // Pipeline ignoring pipe_hold: FIFO fills and offers are back-pressured
    full_seen = 0;
    repeat (60) begin
      step(100, 1'b0, 90, 20);
      if (mq.size() == DEPTH) full_seen++;
    end
    chk("fifo_reached_full", 64'(full_seen > 0), 64'(1));

    // Asynchronous reset with buffered results and pending bits
    begin
      bit acc;
      @(posedge clk);
      #1;
      model_edge(acc);
      zero_inputs();
      #2;
      in_reset = 1'b1;
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      mq.delete();
      exp_q.delete();
      mpend = '0;
      mstarve = 0;
      mhold = 1'b0;
      last_lu_addr = 0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      in_reset = 1'b0;
    end
    // Idle after release: any write here is unexpected
    repeat (5) step(0, 1'b1, 0, 0);

    repeat (400) step(60, 1'b1, 50, 40);

    // Drain with bounded wait
    for (int i = 0; i < 200; i++) begin
      if (mq.size() == 0 && exp_q.size() == 0 && !lu_valid) break;
      step(0, 1'b1, 0, 0);
    end
    @(negedge clk);
    #1;
    chk("drain_exp_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_fifo_empty", 64'(mq.size()), 64'(0));
    repeat (4) step(0, 1'b1, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter and scoreboard sitting directly upstream of the register file's single write port.
- Merges two result sources onto that port:
  - the in-order pipeline result, one per cycle and never buffered;
  - results from the long-latency unit (mul/div/load), held in a small FIFO.
- Tracks which registers are waiting on a long-latency result and drives the issue-stage stall for RAW/WAW hazards.

Parameters:
- FIFO_DEPTH, 4: long-latency result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive cycles the FIFO head may be blocked by the pipeline before pipe_hold asserts; ≥1.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- pipe_valid  input  1  pipeline writeback request this cycle.
- pipe_addr  input  5  pipeline destination register.
- pipe_data  input  32  pipeline result.
- pipe_hold  output  1  request for the pipeline to insert a writeback bubble.
- lu_valid  input  1  long-latency result offered.
- lu_ready  output  1  FIFO can accept.
- lu_addr  input  5  long-latency destination register.
- lu_data  input  32  long-latency result.
- issue_lu_valid  input  1  a long-latency op is issuing this cycle.
- issue_lu_addr  input  5  its destination register.
- rs1_addr, rs2_addr, rd_addr  input  5 each  issue-stage operand and destination indices.
- stall  output  1  issue-stage hazard stall.
- pending  output  32  scoreboard bitmap; bit 0 is always 0.
- we  output  1  register file write enable.
- wb_addr  output  5  register file write address.
- wb_data  output  32  register file write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - Cleared: we, wb_addr, wb_data, pending, FIFO pointers/count, starvation counter, and the internal from-LU flag.
  - Outputs in reset: lu_ready=1, pipe_hold=0, stall=0.
  - Reset mid-operation discards all buffered results.
- Output register: we/wb_addr/wb_data are registered and load every cycle.
- Selection each cycle, in priority order:
  1. pipe_valid=1 → load pipeline result.
  2. Else if FIFO non-empty → pop head and load it.
  3. Else → we=0.
- Latency:
  - Pipeline: pipe_valid in cycle t → we=1 in cycle t+1.
  - Long-latency: accepted in cycle t → earliest pop in t+1 → we=1 in t+2.
  - There is no FIFO bypass.
- Writes to x0: a selected entry with addr 0 produces we=0. A FIFO entry is still popped.
- FIFO:
  - Push when lu_valid & lu_ready.
  - lu_ready = !full, derived from registered state only.
  - Push and pop in the same cycle are allowed when non-full; count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - lu_valid while lu_ready=0 is ignored; the source must hold its data.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and pipe_valid=1.
  - It resets to 0 on any pop or when the FIFO is empty.
  - pipe_hold=1 (registered) once the counter reaches STARVE_LIMIT; it stays 1 until the next pop.
  - The pipeline must drive pipe_valid=0 in the cycle after it sees pipe_hold. If pipe_valid=1 arrives anyway, the pipeline still wins.
- Scoreboard:
  - issue_lu_valid with addr≠0 sets pending[addr] at the clock edge.
  - pending[a] clears at the edge ending the cycle in which we=1, wb_addr=a, and the write came from the FIFO.
  - Set and clear of the same bit on the same edge: set wins.
  - Pipeline writes never clear pending.
- Stall: stall = pending[rs1_addr] | pending[rd_addr] | pending[rs2_addr], combinational from the registered bitmap; index 0 always contributes 0.
- Hazard guarantee: the register file read is asynchronous. Because pending clears only after the write edge, the first cycle with stall=0 reads the new value.

Test Plan:
- Reset mid-flight: FIFO holds 2 entries and pending has bits 5 and 9 set; pull reset low → we=0, pending=0, lu_ready=1 immediately; after release, nothing is written.
- Pipeline only: pipe_valid=1, addr 3, data 0xDEADBEEF in cycle t → we=1, wb_addr=3, wb_data=0xDEADBEEF in t+1; addr 0 case → we=0.
- Long-latency path with scoreboard:
  - Issue addr 7 → pending[7]=1; rs1_addr=7 → stall=1.
  - Push lu addr 7, data 0x12345678 at t → we=1 at t+2; pending[7]=0 and stall=0 at t+3.
- Priority and starvation with STARVE_LIMIT=8: FIFO has 1 entry, pipe_valid held 1 → no pop; pipe_hold=1 after 8 cycles; pipeline bubbles → head written, pipe_hold drops.
- FIFO full (DEPTH=4): push 4 entries while pipe_valid=1 → lu_ready=0, 5th offer held; release → 4 writes in FIFO order, then the 5th.
- Same-edge set/clear: issue addr 4 on the cycle the older addr-4 FIFO write commits → pending[4] stays 1.
